// File: rtl/match_pe_scoreboard.sv
// ============================================================================
// match_pe_scoreboard
//
// Job scoreboard in front of the match PE pipeline.  Each accepted job
// (head address, history address) is allocated to one of 2^SCOREBOARD_ENTRY_INDEX
// entries.  Entries issue PE_WIDTH-byte compare chunks to the PE one at a time,
// accumulate the returned per-chunk match lengths, and stop on the first
// partial chunk or after the final permitted chunk.  Final lengths leave in
// job-acceptance order.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   job_valid / job_ready       job handshake; job_ready means the entry at the
//                               allocation pointer is (or is becoming) free
//   job_head_addr/job_hist_addr job byte addresses
//   pe_valid, pe_idx, pe_last   registered chunk request to the PE
//   pe_head_addr/pe_history_addr base + k*PE_WIDTH
//   res_valid, res_last,        PE result, echoing pe_idx / pe_last
//   res_idx, res_match_len
//   out_valid / out_ready       final result handshake
//   out_match_len, out_hist_addr total length and history address of the job
// ============================================================================
module match_pe_scoreboard #(
    parameter int SCOREBOARD_ENTRY_INDEX = 2,
    parameter int ADDR_WIDTH             = 16,
    parameter int PE_WIDTH               = 32,
    parameter int MAX_LEN_LOG2           = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              job_valid,
    output logic                              job_ready,
    input  logic [ADDR_WIDTH-1:0]             job_head_addr,
    input  logic [ADDR_WIDTH-1:0]             job_hist_addr,
    output logic                              pe_valid,
    output logic [SCOREBOARD_ENTRY_INDEX-1:0] pe_idx,
    output logic                              pe_last,
    output logic [ADDR_WIDTH-1:0]             pe_head_addr,
    output logic [ADDR_WIDTH-1:0]             pe_history_addr,
    input  logic                              res_valid,
    input  logic                              res_last,
    input  logic [SCOREBOARD_ENTRY_INDEX-1:0] res_idx,
    input  logic [MAX_LEN_LOG2:0]             res_match_len,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAX_LEN_LOG2:0]             out_match_len,
    output logic [ADDR_WIDTH-1:0]             out_hist_addr
);

    localparam int SEI      = SCOREBOARD_ENTRY_INDEX;
    localparam int NE       = 1 << SEI;
    localparam int CHUNKS   = (1 << MAX_LEN_LOG2) / PE_WIDTH;
    localparam int K_W      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int LEN_W    = MAX_LEN_LOG2 + 1;
    localparam int PE_SHIFT = $clog2(PE_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } entry_state_e;

    // Per-entry storage
    entry_state_e          state_q [NE];
    entry_state_e          state_d [NE];
    logic [ADDR_WIDTH-1:0] head_q  [NE];
    logic [ADDR_WIDTH-1:0] hist_q  [NE];
    logic [K_W-1:0]        k_q     [NE];
    logic [K_W-1:0]        k_d     [NE];
    logic [LEN_W-1:0]      acc_q   [NE];
    logic [LEN_W-1:0]      acc_d   [NE];

    // Pointers and arbiter history
    logic [SEI-1:0]        alloc_ptr_q;
    logic [SEI-1:0]        retire_ptr_q;
    logic [SEI-1:0]        last_grant_q;

    // PE request register
    logic                  pe_valid_q;
    logic [SEI-1:0]        pe_idx_q;
    logic                  pe_last_q;
    logic [ADDR_WIDTH-1:0] pe_head_q;
    logic [ADDR_WIDTH-1:0] pe_hist_q;
    logic [SEI-1:0]        pe_idx_d;
    logic                  pe_last_d;
    logic [ADDR_WIDTH-1:0] pe_head_d;
    logic [ADDR_WIDTH-1:0] pe_hist_d;

    // Handshake and arbiter decisions
    logic                  alloc_fire_s;
    logic                  retire_fire_s;
    logic                  grant_valid_s;
    logic [SEI-1:0]        grant_idx_s;
    logic [SEI-1:0]        cand_s;
    logic                  hit_s;
    logic [ADDR_WIDTH-1:0] pe_offset_s;

    // Retire side is a plain view of the entry under the retire pointer.
    assign out_valid     = (state_q[retire_ptr_q] == ST_DONE);
    assign out_match_len = acc_q[retire_ptr_q];
    assign out_hist_addr = hist_q[retire_ptr_q];
    assign retire_fire_s = out_valid && out_ready;

    // Retire is resolved before allocation: an entry leaving DONE this cycle
    // may be refilled in the same cycle.
    assign job_ready    = (state_q[alloc_ptr_q] == ST_IDLE) ||
                          (retire_fire_s && (retire_ptr_q == alloc_ptr_q));
    assign alloc_fire_s = job_valid && job_ready;

    assign pe_valid        = pe_valid_q;
    assign pe_idx          = pe_idx_q;
    assign pe_last         = pe_last_q;
    assign pe_head_addr    = pe_head_q;
    assign pe_history_addr = pe_hist_q;

    // Round-robin arbiter: scan ISSUE entries starting just after the last grant.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = last_grant_q;
        cand_s        = last_grant_q;
        hit_s         = 1'b0;
        for (int off = 1; off <= NE; off++) begin
            cand_s        = last_grant_q + SEI'(off);
            hit_s         = !grant_valid_s && (state_q[cand_s] == ST_ISSUE);
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_valid_s = grant_valid_s | hit_s;
        end
    end

    // Next request contents for the granted entry; hold previous values otherwise.
    always_comb begin
        pe_offset_s = ADDR_WIDTH'(k_q[grant_idx_s]) << PE_SHIFT;
        if (grant_valid_s) begin
            pe_idx_d  = grant_idx_s;
            pe_last_d = (k_q[grant_idx_s] == K_W'(CHUNKS - 1));
            pe_head_d = head_q[grant_idx_s] + pe_offset_s;
            pe_hist_d = hist_q[grant_idx_s] + pe_offset_s;
        end else begin
            pe_idx_d  = pe_idx_q;
            pe_last_d = pe_last_q;
            pe_head_d = pe_head_q;
            pe_hist_d = pe_hist_q;
        end
    end

    // Per-entry state machine: allocation, issue grant, result accumulation, retire.
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            state_d[i] = state_q[i];
            k_d[i]     = k_q[i];
            acc_d[i]   = acc_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (alloc_fire_s && (alloc_ptr_q == SEI'(i))) begin
                        state_d[i] = ST_ISSUE;
                        k_d[i]     = {K_W{1'b0}};
                        acc_d[i]   = {LEN_W{1'b0}};
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (grant_valid_s && (grant_idx_s == SEI'(i))) begin
                        state_d[i] = ST_WAIT;
                    end else begin
                        state_d[i] = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    // res_idx is unique because each entry has at most one request in flight.
                    if (res_valid && (res_idx == SEI'(i))) begin
                        acc_d[i] = acc_q[i] + res_match_len;
                        if ((res_match_len == LEN_W'(PE_WIDTH)) && !res_last) begin
                            k_d[i]     = k_q[i] + K_W'(1);
                            state_d[i] = ST_ISSUE;
                        end else begin
                            state_d[i] = ST_DONE;
                        end
                    end else begin
                        state_d[i] = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (retire_fire_s && (retire_ptr_q == SEI'(i))) begin
                        if (alloc_fire_s && (alloc_ptr_q == SEI'(i))) begin
                            state_d[i] = ST_ISSUE;
                            k_d[i]     = {K_W{1'b0}};
                            acc_d[i]   = {LEN_W{1'b0}};
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else begin
                        state_d[i] = ST_DONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Entry state, counters and accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                state_q[i] <= ST_IDLE;
                k_q[i]     <= {K_W{1'b0}};
                acc_q[i]   <= {LEN_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NE; i++) begin
                state_q[i] <= state_d[i];
                k_q[i]     <= k_d[i];
                acc_q[i]   <= acc_d[i];
            end
        end
    end

    // Job base addresses, captured on allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                head_q[i] <= {ADDR_WIDTH{1'b0}};
                hist_q[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else if (alloc_fire_s) begin
            head_q[alloc_ptr_q] <= job_head_addr;
            hist_q[alloc_ptr_q] <= job_hist_addr;
        end else begin
            head_q[alloc_ptr_q] <= head_q[alloc_ptr_q];
        end
    end

    // Allocation, retire and arbiter pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr_q  <= {SEI{1'b0}};
            retire_ptr_q <= {SEI{1'b0}};
            last_grant_q <= {SEI{1'b1}};
        end else begin
            alloc_ptr_q  <= alloc_fire_s  ? alloc_ptr_q + SEI'(1)  : alloc_ptr_q;
            retire_ptr_q <= retire_fire_s ? retire_ptr_q + SEI'(1) : retire_ptr_q;
            last_grant_q <= grant_valid_s ? grant_idx_s            : last_grant_q;
        end
    end

    // Registered PE request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_valid_q <= 1'b0;
            pe_idx_q   <= {SEI{1'b0}};
            pe_last_q  <= 1'b0;
            pe_head_q  <= {ADDR_WIDTH{1'b0}};
            pe_hist_q  <= {ADDR_WIDTH{1'b0}};
        end else begin
            pe_valid_q <= grant_valid_s;
            pe_idx_q   <= pe_idx_d;
            pe_last_q  <= pe_last_d;
            pe_head_q  <= pe_head_d;
            pe_hist_q  <= pe_hist_d;
        end
    end

endmodule

// File: tb/tb_match_pe_scoreboard.sv
// Directed bench for match_pe_scoreboard with a latency-5 behavioural PE model
// and an in-order scoreboard of expected final results.
module tb_match_pe_scoreboard;

    localparam int AW   = 16;
    localparam int PEW  = 32;
    localparam int LAT  = 5;
    localparam int MAXJ = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_head_addr;
    logic [AW-1:0] job_hist_addr;
    logic          pe_valid;
    logic [1:0]    pe_idx;
    logic          pe_last;
    logic [AW-1:0] pe_head_addr;
    logic [AW-1:0] pe_history_addr;
    logic          res_valid;
    logic          res_last;
    logic [1:0]    res_idx;
    logic [8:0]    res_match_len;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_match_len;
    logic [AW-1:0] out_hist_addr;

    match_pe_scoreboard #(
        .SCOREBOARD_ENTRY_INDEX(2),
        .ADDR_WIDTH            (AW),
        .PE_WIDTH              (PEW),
        .MAX_LEN_LOG2          (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_head_addr  (job_head_addr),
        .job_hist_addr  (job_hist_addr),
        .pe_valid       (pe_valid),
        .pe_idx         (pe_idx),
        .pe_last        (pe_last),
        .pe_head_addr   (pe_head_addr),
        .pe_history_addr(pe_history_addr),
        .res_valid      (res_valid),
        .res_last       (res_last),
        .res_idx        (res_idx),
        .res_match_len  (res_match_len),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_match_len  (out_match_len),
        .out_hist_addr  (out_hist_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Job table (bench model)
    int jh [MAXJ];
    int jhist [MAXJ];
    int jlen [MAXJ];
    int jentry [MAXJ];
    int req_cnt [MAXJ];
    int acc_cyc [MAXJ];
    int first_req_cyc [MAXJ];
    int ret_cyc [MAXJ];
    int njobs     = 0;
    int cur_job   = -1;
    int alloc_cnt = 0;
    bit accepted  = 1'b0;
    int sbq [$];
    int req_log [$];

    // PE model pipeline
    bit         pv [LAT]    = '{default: 1'b0};
    logic [1:0] pidx [LAT]  = '{default: 2'd0};
    bit         plast [LAT] = '{default: 1'b0};
    logic [8:0] plen [LAT]  = '{default: 9'd0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int nreq(input int len);
        int n;
        n = len / PEW + 1;
        return (n > 8) ? 8 : n;
    endfunction

    // Behavioural PE: consumes a request each negedge it is valid, answers LAT cycles later.
    always @(negedge clk) begin
        bit         o_v;
        logic [1:0] o_idx;
        bit         o_last;
        logic [8:0] o_len;
        int         j;
        int         chunk;
        int         rem;
        o_v    = pv[LAT-1];
        o_idx  = pidx[LAT-1];
        o_last = plast[LAT-1];
        o_len  = plen[LAT-1];
        for (int s = LAT - 1; s > 0; s--) begin
            pv[s]    = pv[s-1];
            pidx[s]  = pidx[s-1];
            plast[s] = plast[s-1];
            plen[s]  = plen[s-1];
        end
        pv[0] = 1'b0;
        if (pe_valid === 1'b1) begin
            j = -1;
            for (int q = 0; q < njobs; q++)
                if (int'(pe_head_addr) >= jh[q] && int'(pe_head_addr) < jh[q] + 256) j = q;
            chk("req_known_job", (j >= 0), 1);
            if (j >= 0) begin
                chunk = (int'(pe_head_addr) - jh[j]) / PEW;
                chk("req_head_aligned", int'(pe_head_addr), jh[j] + chunk * PEW);
                chk("req_order", chunk, req_cnt[j]);
                chk("req_in_range", (chunk < nreq(jlen[j])), 1);
                chk("req_hist_addr", pe_history_addr, (jhist[j] + chunk * PEW) % 65536);
                chk("req_last", pe_last, (chunk == 7));
                chk("req_idx", pe_idx, jentry[j]);
                if (req_cnt[j] == 0) first_req_cyc[j] = cyc;
                req_cnt[j]++;
                req_log.push_back(j);
                rem = jlen[j] - chunk * PEW;
                if (rem < 0) rem = 0;
                if (rem > PEW) rem = PEW;
                pv[0]    = 1'b1;
                pidx[0]  = pe_idx;
                plast[0] = pe_last;
                plen[0]  = 9'(rem);
            end
        end
        res_valid     = o_v;
        res_idx       = o_idx;
        res_last      = o_last;
        res_match_len = o_len;
    end

    // One cycle: resolve handshakes (push on accept, pop and compare on retire).
    task automatic step();
        int j;
        #2;
        if (job_valid && job_ready) begin
            chk("accept_expected", (cur_job >= 0), 1);
            if (cur_job >= 0) begin
                sbq.push_back(cur_job);
                jentry[cur_job]  = alloc_cnt;
                alloc_cnt        = (alloc_cnt + 1) % 4;
                acc_cyc[cur_job] = cyc;
                accepted         = 1'b1;
            end
        end
        if (out_valid && out_ready) begin
            chk("retire_has_expect", (sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                j = sbq.pop_front();
                chk("out_match_len", out_match_len, jlen[j]);
                chk("out_hist_addr", out_hist_addr, jhist[j]);
                chk("req_count", req_cnt[j], nreq(jlen[j]));
                ret_cyc[j] = cyc;
            end
        end
        @(negedge clk);
    endtask

    task automatic offer(input int head, input int hist, input int len, output int id);
        id             = njobs;
        jh[id]         = head;
        jhist[id]      = hist;
        jlen[id]       = len;
        req_cnt[id]    = 0;
        njobs++;
        cur_job        = id;
        accepted       = 1'b0;
        job_head_addr  = AW'(head);
        job_hist_addr  = AW'(hist);
        job_valid      = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) step();
        job_valid = 1'b0;
        cur_job   = -1;
        chk("job_accepted", accepted, 1);
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int t = 0; t < budget && sbq.size() > 0; t++) step();
        chk("drain_done", sbq.size(), 0);
    endtask

    initial begin
        int j0, j1, j2, j3, jx;
        rst           = 1'b1;
        job_valid     = 1'b0;
        job_head_addr = '0;
        job_hist_addr = '0;
        out_ready     = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pe_valid", pe_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pe_idx", pe_idx, 0);
        chk("rst_pe_last", pe_last, 0);
        chk("rst_pe_head", pe_head_addr, 0);
        chk("rst_pe_hist", pe_history_addr, 0);
        chk("rst_out_len", out_match_len, 0);
        chk("rst_out_hist", out_hist_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_job_ready", job_ready, 1);
        @(negedge clk);

        // 70-byte match: chunks 32,32,6
        offer(16'h0100, 16'h0040, 70, j0);
        drain(100);
        // exact 64: chunks 32,32,0
        offer(16'h0300, 16'h0080, 64, j0);
        drain(100);
        // full match: 8 chunks, last flagged on k=7
        offer(16'h0500, 16'h00C0, 256, j0);
        drain(200);
        // first-byte mismatch with latency check
        offer(16'h0700, 16'h0010, 0, j0);
        drain(100);
        chk("lat_first_req", first_req_cyc[j0] - acc_cyc[j0], 2);
        chk("lat_out_valid", ret_cyc[j0] - acc_cyc[j0], 8);
        #2;
        chk("idle_pe_valid", pe_valid, 0);
        chk("empty_out_valid", out_valid, 0);
        @(negedge clk);

        // Four back-to-back jobs with the output stalled
        out_ready = 1'b0;
        req_log.delete();
        offer(16'h0900, 16'h0011, 256, j0);
        offer(16'h0B00, 16'h0022, 0, j1);
        offer(16'h0D00, 16'h0033, 0, j2);
        offer(16'h0F00, 16'h0044, 0, j3);
        job_valid     = 1'b1;
        job_head_addr = 16'h1F00;
        #2;
        chk("full_job_ready", job_ready, 0);
        job_valid = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 200 && !out_valid; t++) step();
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_len", out_match_len, 256);
            chk("stall_out_hist", out_hist_addr, 16'h0011);
            step();
        end
        drain(100);
        chk("rr_log_size", (req_log.size() >= 5), 1);
        chk("rr_order0", req_log[0], j0);
        chk("rr_order1", req_log[1], j1);
        chk("rr_order2", req_log[2], j2);
        chk("rr_order3", req_log[3], j3);
        chk("rr_order4", req_log[4], j0);

        // Reset while three entries wait on the PE
        out_ready = 1'b1;
        offer(16'h1100, 16'h0055, 256, j0);
        offer(16'h1300, 16'h0066, 256, j1);
        offer(16'h1500, 16'h0077, 256, j2);
        step();
        chk("pre_rst_pe_valid", pe_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_pe_valid", pe_valid, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        sbq.delete();
        alloc_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_job_ready", job_ready, 1);
        @(negedge clk);
        for (int t = 0; t < 10; t++) step();
        chk("stale_ignored", out_valid, 0);
        offer(16'h1700, 16'h0088, 100, jx);
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
